// File: rtl/int_ack_pkg.sv
// Shared types and default sizing for the tick-to-interrupt controller.
// Optional ack timeout is enabled with the INT_TIMEOUT_EN macro.
package int_ack_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } chan_state_t;

    localparam int unsigned DEF_NUM_CPU        = 2;
    localparam int unsigned DEF_OVR_WIDTH      = 8;
    localparam int unsigned DEF_TICK_WIDTH     = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    // Width of a counter that must hold values 0 .. n-1 (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_ack_chan.sv
// One interrupt channel: IDLE/PEND FSM, saturating overrun counter and,
// with INT_TIMEOUT_EN defined, an ack timeout with a sticky flag.
module int_ack_chan
    import int_ack_pkg::*;
#(
    parameter int unsigned OVR_WIDTH      = DEF_OVR_WIDTH
`ifdef INT_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 en,
    input  logic                 ack,
    input  logic                 ovr_clr,
    output logic                 interrupt,
    output logic [OVR_WIDTH-1:0] ovr_cnt,
    output logic                 timeout_flag
);

    chan_state_t          state;
    logic [OVR_WIDTH-1:0] ovr_next;

    always_comb ovr_next = (ovr_cnt == '1) ? ovr_cnt : ovr_cnt + 1'b1;

`ifdef INT_TIMEOUT_EN
    localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] pend_cnt;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
            ovr_cnt   <= '0;
`ifdef INT_TIMEOUT_EN
            timeout_flag <= 1'b0;
            pend_cnt     <= '0;
`endif
        end else begin
            // Clear first so a same-cycle overrun below overrides it with 1.
            if (ovr_clr) begin
                ovr_cnt <= '0;
`ifdef INT_TIMEOUT_EN
                timeout_flag <= 1'b0;
`endif
            end
            case (state)
                ST_IDLE: begin
                    if (tick && en) begin
                        state     <= ST_PEND;
                        interrupt <= 1'b1;
`ifdef INT_TIMEOUT_EN
                        pend_cnt  <= '0;
`endif
                    end
                end
                ST_PEND: begin
                    if (!en) begin
                        state     <= ST_IDLE;
                        interrupt <= 1'b0;
                    end
`ifdef INT_TIMEOUT_EN
                    // Timeout acts as a drop to IDLE; a coincident tick re-arms.
                    else if (!ack && pend_cnt == TO_LAST) begin
                        timeout_flag <= 1'b1;
                        if (tick) begin
                            pend_cnt <= '0;
                        end else begin
                            state     <= ST_IDLE;
                            interrupt <= 1'b0;
                        end
                    end
`endif
                    else if (ack) begin
                        if (!tick) begin
                            state     <= ST_IDLE;
                            interrupt <= 1'b0;
                        end
`ifdef INT_TIMEOUT_EN
                        else begin
                            pend_cnt <= '0;
                        end
`endif
                    end else begin
                        if (tick) begin
                            ovr_cnt <= ovr_clr ? OVR_WIDTH'(1) : ovr_next;
                        end
`ifdef INT_TIMEOUT_EN
                        pend_cnt <= pend_cnt + 1'b1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/int_ack_ctrl.sv
// Tick-to-interrupt controller: one int_ack_chan per PicoBlaze plus a
// free-running tick counter. INT_TIMEOUT_EN enables per-channel ack timeouts.
module int_ack_ctrl
    import int_ack_pkg::*;
#(
    parameter int unsigned NUM_CPU        = DEF_NUM_CPU,
    parameter int unsigned OVR_WIDTH      = DEF_OVR_WIDTH,
    parameter int unsigned TICK_WIDTH     = DEF_TICK_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick_in,
    input  logic [NUM_CPU-1:0]             int_en,
    input  logic [NUM_CPU-1:0]             interrupt_ack,
    input  logic                           ovr_clr,
    output logic [NUM_CPU-1:0]             interrupt,
    output logic [NUM_CPU*OVR_WIDTH-1:0]   ovr_cnt,
    output logic [TICK_WIDTH-1:0]          tick_count,
    output logic [NUM_CPU-1:0]             timeout_flag
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_count <= '0;
        end else if (tick_in) begin
            tick_count <= tick_count + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CPU; i++) begin : g_chan
        int_ack_chan #(
            .OVR_WIDTH(OVR_WIDTH)
`ifdef INT_TIMEOUT_EN
            , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .tick         (tick_in),
            .en           (int_en[i]),
            .ack          (interrupt_ack[i]),
            .ovr_clr      (ovr_clr),
            .interrupt    (interrupt[i]),
            .ovr_cnt      (ovr_cnt[i*OVR_WIDTH +: OVR_WIDTH]),
            .timeout_flag (timeout_flag[i])
        );
    end

endmodule

// File: tb/tb_int_ack_ctrl.sv
// Scoreboard bench for int_ack_ctrl (OVR_WIDTH=2, TIMEOUT_CYCLES=8); the
// timeout scenario follows INT_TIMEOUT_EN.
module tb_int_ack_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_in;
    logic [1:0]  int_en;
    logic [1:0]  interrupt_ack;
    logic        ovr_clr;
    logic [1:0]  interrupt;
    logic [3:0]  ovr_cnt;
    logic [15:0] tick_count;
    logic [1:0]  timeout_flag;

    int_ack_ctrl #(
        .NUM_CPU        (2),
        .OVR_WIDTH      (2),
        .TICK_WIDTH     (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_in       (tick_in),
        .int_en        (int_en),
        .interrupt_ack (interrupt_ack),
        .ovr_clr       (ovr_clr),
        .interrupt     (interrupt),
        .ovr_cnt       (ovr_cnt),
        .tick_count    (tick_count),
        .timeout_flag  (timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          step;
        logic [1:0]  intr;
        logic [3:0]  ovr;
        logic [15:0] tc;
        logic [1:0]  tf;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   step_no = 0;

    logic [1:0] exp_int = '0;
    logic [3:0] exp_ovr = '0;
    logic [1:0] exp_tf  = '0;
    int         exp_tc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int step, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, step, got, want);
        end
    endtask

    // Monitor: pops every expectation due at or before the current cycle.
    exp_t mon_e;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            chk("sched", mon_e.step, 16'(cyc), 16'(mon_e.cyc));
            chk("interrupt", mon_e.step, {14'b0, interrupt}, {14'b0, mon_e.intr});
            chk("ovr_cnt", mon_e.step, {12'b0, ovr_cnt}, {12'b0, mon_e.ovr});
            chk("tick_count", mon_e.step, tick_count, mon_e.tc);
            chk("timeout_flag", mon_e.step, {14'b0, timeout_flag}, {14'b0, mon_e.tf});
        end
    end

    // Apply one cycle of inputs and queue the state expected after that edge.
    task automatic drive(input logic [1:0] en, input logic tk, input logic [1:0] ack, input logic clr);
        exp_t e;
        int_en = en;
        tick_in = tk;
        interrupt_ack = ack;
        ovr_clr = clr;
        if (!reset) exp_tc = 0;
        else if (tk) exp_tc++;
        e.cyc  = cyc + 1;
        e.step = step_no;
        e.intr = exp_int;
        e.ovr  = exp_ovr;
        e.tc   = exp_tc[15:0];
        e.tf   = exp_tf;
        sb.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
        tick_in = 1'b0;
        interrupt_ack = 2'b00;
        ovr_clr = 1'b0;
    endtask

    task automatic idle(input logic [1:0] en, input int n);
        for (int k = 0; k < n; k++) drive(en, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        tick_in = 1'b0;
        int_en = 2'b00;
        interrupt_ack = 2'b00;
        ovr_clr = 1'b0;

        // Reset holds everything at zero, even with a tick and enables.
        drive(2'b00, 1'b0, 2'b00, 1'b0);
        drive(2'b11, 1'b1, 2'b00, 1'b0);
        drive(2'b00, 1'b0, 2'b00, 1'b0);
        reset = 1'b1;
        idle(2'b11, 2);

        // Tick raises both interrupts; acks drop them one at a time.
        exp_int = 2'b11; drive(2'b11, 1'b1, 2'b00, 1'b0);
        idle(2'b11, 3);
        exp_int = 2'b10; drive(2'b11, 1'b0, 2'b01, 1'b0);
        idle(2'b11, 2);
        exp_int = 2'b00; drive(2'b11, 1'b0, 2'b10, 1'b0);
        drive(2'b11, 1'b0, 2'b11, 1'b0);
        drive(2'b00, 1'b1, 2'b00, 1'b0);

        // Overruns on channel 0 only, then clear.
        exp_int = 2'b01; drive(2'b01, 1'b1, 2'b00, 1'b0);
        exp_ovr = 4'b0001; drive(2'b01, 1'b1, 2'b00, 1'b0);
        exp_ovr = 4'b0010; drive(2'b01, 1'b1, 2'b00, 1'b0);
        exp_ovr = 4'b0011; drive(2'b01, 1'b1, 2'b00, 1'b0);
        idle(2'b01, 1);
        exp_ovr = 4'b0000; drive(2'b01, 1'b0, 2'b00, 1'b1);
        drive(2'b01, 1'b1, 2'b01, 1'b0);

        // Saturation at 3, then overrun coinciding with clear leaves 1.
        for (int i = 0; i < 6; i++) begin
            exp_ovr = (i < 3) ? 4'(i + 1) : 4'd3;
            drive(2'b01, 1'b1, 2'b00, 1'b0);
        end
        exp_ovr = 4'b0001; drive(2'b01, 1'b1, 2'b00, 1'b1);
        exp_int = 2'b00; exp_ovr = 4'b0000; drive(2'b01, 1'b0, 2'b01, 1'b1);

        // Tick+ack keeps pending without overrun; disable drops the channel.
        exp_int = 2'b11; drive(2'b11, 1'b1, 2'b00, 1'b0);
        drive(2'b11, 1'b1, 2'b11, 1'b0);
        idle(2'b11, 2);
        exp_ovr = 4'b0001; drive(2'b11, 1'b1, 2'b10, 1'b0);
        exp_int = 2'b01; drive(2'b01, 1'b0, 2'b00, 1'b0);
        exp_ovr = 4'b0010; drive(2'b01, 1'b1, 2'b00, 1'b0);
        exp_int = 2'b11; exp_ovr = 4'b0011; drive(2'b11, 1'b1, 2'b00, 1'b0);
        exp_ovr = 4'b0111; drive(2'b11, 1'b1, 2'b00, 1'b0);
        exp_int = 2'b00; drive(2'b11, 1'b0, 2'b11, 1'b0);
        exp_ovr = 4'b0000; drive(2'b11, 1'b0, 2'b00, 1'b1);

        // Bulk ticks with channels disabled, bringing the total to 70000.
        n = 70000 - exp_tc;
        int_en = 2'b00;
        for (int k = 0; k < n; k++) begin
            tick_in = 1'b1;
            @(posedge clk);
            #1;
        end
        tick_in = 1'b0;
        exp_tc += n;
        drive(2'b00, 1'b0, 2'b00, 1'b0);

`ifdef INT_TIMEOUT_EN
        // Plain timeout after 8 pending cycles.
        exp_int = 2'b01; drive(2'b01, 1'b1, 2'b00, 1'b0);
        idle(2'b01, 7);
        exp_int = 2'b00; exp_tf = 2'b01; drive(2'b01, 1'b0, 2'b00, 1'b0);
        idle(2'b01, 1);
        exp_tf = 2'b00; drive(2'b01, 1'b0, 2'b00, 1'b1);
        // Ack in the timeout cycle wins.
        exp_int = 2'b01; drive(2'b01, 1'b1, 2'b00, 1'b0);
        idle(2'b01, 7);
        exp_int = 2'b00; drive(2'b01, 1'b0, 2'b01, 1'b0);
        // An overrun tick does not restart the timeout.
        exp_int = 2'b01; drive(2'b01, 1'b1, 2'b00, 1'b0);
        idle(2'b01, 3);
        exp_ovr = 4'b0001; drive(2'b01, 1'b1, 2'b00, 1'b0);
        idle(2'b01, 3);
        exp_int = 2'b00; exp_tf = 2'b01; drive(2'b01, 1'b0, 2'b00, 1'b0);
        exp_ovr = 4'b0000; exp_tf = 2'b00; drive(2'b01, 1'b0, 2'b00, 1'b1);
        // Tick in the timeout cycle re-arms a fresh pending period.
        exp_int = 2'b01; drive(2'b01, 1'b1, 2'b00, 1'b0);
        idle(2'b01, 7);
        exp_tf = 2'b01; drive(2'b01, 1'b1, 2'b00, 1'b0);
        idle(2'b01, 7);
        exp_int = 2'b00; drive(2'b01, 1'b0, 2'b00, 1'b0);
`else
        // Without timeouts the interrupt is held until acked.
        exp_int = 2'b01; drive(2'b01, 1'b1, 2'b00, 1'b0);
        idle(2'b01, 100);
        exp_int = 2'b00; drive(2'b01, 1'b0, 2'b01, 1'b0);
`endif

        // Reset while pending drops the interrupt on the next edge.
        exp_int = 2'b01; drive(2'b01, 1'b1, 2'b00, 1'b0);
        reset = 1'b0;
        exp_int = 2'b00; exp_ovr = 4'b0000; exp_tf = 2'b00;
        drive(2'b01, 1'b0, 2'b00, 1'b0);
        reset = 1'b1;
        idle(2'b01, 2);

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
